// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, field positions and strobe decode for the 9-bit core
package cpu_pkg;

    typedef enum logic [1:0] {
        CLS_R = 2'b00,
        CLS_M = 2'b01,
        CLS_B = 2'b10,
        CLS_S = 2'b11
    } instr_class_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_t;

    localparam int INSTR_W  = 9;
    localparam int CLASS_HI = 8;
    localparam int CLASS_LO = 7;
    localparam int LS_BIT   = 6;   // 1 = load, 0 = store within the M class
    localparam int OFF_HI   = 5;
    localparam int OFF_LO   = 0;
    localparam int OFF_W    = OFF_HI - OFF_LO + 1;

    localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 9'h1FF;

    typedef struct packed {
        logic imem_rd;
        logic alu_en;
        logic mem_req;
        logic mem_we;
        logic reg_we;
        logic busy;
        logic done;
    } strobes_t;

    // Strobe pattern for the state being entered; is_load only matters for MEM.
    function automatic strobes_t strobes_for(seq_state_t s, logic is_load);
        strobes_t r;
        r.imem_rd = (s == ST_FETCH);
        r.alu_en  = (s == ST_EXEC);
        r.mem_req = (s == ST_MEM);
        r.mem_we  = (s == ST_MEM) && !is_load;
        r.reg_we  = (s == ST_WB);
        r.busy    = (s != ST_IDLE) && (s != ST_HALT);
        r.done    = (s == ST_HALT);
        return r;
    endfunction

    function automatic instr_class_t class_of(logic [INSTR_W-1:0] instr);
        return instr_class_t'(instr[CLASS_HI:CLASS_LO]);
    endfunction

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with clear, increment and signed-offset load
module pc_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             ld_off,
    input  logic [OFF_W-1:0] off,
    output logic [PC_W-1:0]  pc
);

    logic [PC_W-1:0] off_ext;

    assign off_ext = {{(PC_W - OFF_W){off[OFF_W-1]}}, off};

    // PC update; arithmetic wraps modulo 2^PC_W, clear has priority over any step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (ld_off) begin
            pc <= pc + off_ext;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit core
module core_sequencer
    import cpu_pkg::*;
#(
    parameter int                 PC_W      = 10,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               alu_zero,
    input  logic               mem_ack,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               imem_rd,
    output logic               alu_en,
    output logic               mem_req,
    output logic               mem_we,
    output logic               reg_we,
    output logic               busy,
    output logic               done,
    output logic [15:0]        retired
);

    seq_state_t   state;
    strobes_t     strb;
    instr_class_t cls;
    logic         is_load;
    logic         can_start;
    logic         is_branch;
    logic         store_ack;
    logic         retire;

    assign cls       = class_of(ir);
    assign is_load   = ir[LS_BIT];
    assign can_start = start && (state == ST_IDLE || state == ST_HALT);
    assign is_branch = (state == ST_EXEC) && (cls == CLS_B);
    assign store_ack = (state == ST_MEM) && mem_ack && !is_load;
    assign retire    = (state == ST_WB) || store_ack || is_branch;

    assign imem_rd = strb.imem_rd;
    assign alu_en  = strb.alu_en;
    assign mem_req = strb.mem_req;
    assign mem_we  = strb.mem_we;
    assign reg_we  = strb.reg_we;
    assign busy    = strb.busy;
    assign done    = strb.done;

    pc_unit #(.PC_W(PC_W)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .clr    (can_start),
        .inc    ((state == ST_WB) || store_ack || (is_branch && !alu_zero)),
        .ld_off (is_branch && alu_zero),
        .off    (ir[OFF_HI:OFF_LO]),
        .pc     (pc)
    );

    // Sequencer FSM; strobes are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            strb  <= '0;
            ir    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state <= ST_FETCH;
                        strb  <= strobes_for(ST_FETCH, is_load);
                    end
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                    strb  <= strobes_for(ST_DECODE, is_load);
                end
                ST_DECODE: begin
                    ir <= imem_data;
                    if (imem_data == HALT_WORD) begin
                        state <= ST_HALT;
                        strb  <= strobes_for(ST_HALT, 1'b0);
                    end else begin
                        state <= ST_EXEC;
                        strb  <= strobes_for(ST_EXEC, 1'b0);
                    end
                end
                ST_EXEC: begin
                    case (cls)
                        CLS_M: begin
                            state <= ST_MEM;
                            strb  <= strobes_for(ST_MEM, is_load);
                        end
                        CLS_B: begin
                            state <= ST_FETCH;
                            strb  <= strobes_for(ST_FETCH, is_load);
                        end
                        default: begin
                            state <= ST_WB;
                            strb  <= strobes_for(ST_WB, is_load);
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (is_load) begin
                            state <= ST_WB;
                            strb  <= strobes_for(ST_WB, is_load);
                        end else begin
                            state <= ST_FETCH;
                            strb  <= strobes_for(ST_FETCH, is_load);
                        end
                    end
                end
                ST_WB: begin
                    state <= ST_FETCH;
                    strb  <= strobes_for(ST_FETCH, is_load);
                end
                default: begin
                    state <= ST_IDLE;
                    strb  <= '0;
                end
            endcase
        end
    end

    // Retired-instruction counter: cleared on each run start, saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (can_start) begin
            retired <= '0;
        end else if (retire && retired != 16'hFFFF) begin
            retired <= retired + 16'd1;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer
module tb_core_sequencer;

    localparam int         PC_W  = 10;
    localparam int         PC_N  = 1 << PC_W;
    localparam logic [8:0] HW    = 9'h1FF;

    logic            clk = 1'b0;
    logic            reset, start, alu_zero, mem_ack;
    logic [8:0]      imem_data = '0;
    logic [PC_W-1:0] pc;
    logic [8:0]      ir;
    logic            imem_rd, alu_en, mem_req, mem_we, reg_we, busy, done;
    logic [15:0]     retired;

    int checks = 0;
    int errors = 0;

    logic [8:0] rom [PC_N];
    bit         zq  [64];
    int         wq  [64];

    int          e_cyc, e_fetch, e_exec, e_regwe, e_memreq, e_memwe, e_pc;
    logic [15:0] e_ret;
    bit          e_ok;

    int o_busy, o_fetch, o_exec, o_regwe, o_memreq, o_memwe, first_wb;
    bit o_timeout;

    core_sequencer #(.PC_W(PC_W), .HALT_WORD(HW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .imem_data (imem_data),
        .alu_zero  (alu_zero),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .ir        (ir),
        .imem_rd   (imem_rd),
        .alu_en    (alu_en),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .reg_we    (reg_we),
        .busy      (busy),
        .done      (done),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Instruction ROM with one cycle of read latency.
    always @(posedge clk) if (imem_rd) imem_data <= rom[pc];

    task automatic clear_prog();
        for (int i = 0; i < PC_N; i++) rom[i] = HW;
        for (int i = 0; i < 64; i++) begin
            zq[i] = 1'b0;
            wq[i] = 0;
        end
    endtask

    // Instruction-level model: walks the program and sums cycles per instruction.
    task automatic model(input logic [15:0] ret0);
        int p, k, m, off;
        logic [8:0] ins;
        p = 0; k = 0; m = 0;
        e_cyc = 0; e_fetch = 0; e_exec = 0; e_regwe = 0; e_memreq = 0; e_memwe = 0;
        e_pc = 0; e_ret = ret0; e_ok = 0;
        for (int n = 0; n < 50; n++) begin
            ins = rom[p];
            e_fetch++;
            if (ins == HW) begin
                e_cyc += 2;
                e_pc = p;
                e_ok = 1;
                break;
            end
            e_exec++;
            if (ins[8:7] == 2'b10) begin
                e_cyc += 3;
                if (zq[k]) begin
                    off = int'(ins[5:0]);
                    if (off >= 32) off -= 64;
                    p = (p + off + PC_N) % PC_N;
                end else begin
                    p = (p + 1) % PC_N;
                end
            end else if (ins[8:7] == 2'b01) begin
                e_memreq += wq[m] + 1;
                if (ins[6]) begin
                    e_cyc += 5 + wq[m];
                    e_regwe++;
                end else begin
                    e_cyc += 4 + wq[m];
                    e_memwe += wq[m] + 1;
                end
                m++;
                p = (p + 1) % PC_N;
            end else begin
                e_cyc += 4;
                e_regwe++;
                p = (p + 1) % PC_N;
            end
            k++;
            if (e_ret != 16'hFFFF) e_ret++;
        end
    endtask

    // Starts a run and acts as ALU/data-memory environment until done or budget expiry.
    task automatic run_prog(input bit poke);
        int cyc, zi, mi, wcnt, budget;
        cyc = 0; zi = 0; mi = 0; wcnt = 0;
        budget = 400;
        o_busy = 0; o_fetch = 0; o_exec = 0; o_regwe = 0; o_memreq = 0; o_memwe = 0;
        first_wb = 0; o_timeout = 0;
        @(negedge clk);
        start = 1'b1;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (cyc >= budget) begin
                o_timeout = 1;
                break;
            end
            cyc++;
            if (busy) o_busy++;
            if (imem_rd) o_fetch++;
            if (mem_we) o_memwe++;
            if (reg_we) begin
                o_regwe++;
                if (first_wb == 0) first_wb = cyc;
            end
            if (alu_en) begin
                o_exec++;
                alu_zero = zq[zi % 64];
                zi++;
            end else begin
                alu_zero = 1'($urandom);
            end
            if (mem_req) begin
                o_memreq++;
                mem_ack = (wcnt == wq[mi % 64]);
                if (mem_ack) begin
                    mi++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ack = 1'($urandom);
            end
            if (poke && cyc == 1) force dut.retired = 16'hFFFE;
            if (poke && cyc == 2) release dut.retired;
            if (poke && cyc == 5) start = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; alu_zero = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pc, ir, imem_rd, alu_en, mem_req, mem_we, reg_we, busy, done, retired} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pc=%0h ir=%0h busy=%0b done=%0b retired=%0h want all zero",
                     pc, ir, busy, done, retired);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, imem_rd} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got busy=%0b done=%0b imem_rd=%0b want 0 0 0", busy, done, imem_rd);
        end
    endtask

    task automatic test_rtype();
        clear_prog();
        rom[0] = 9'h010;
        run_prog(0);
        checks++; if (o_timeout) begin errors++; $display("FAIL rtype_timeout got no done want done"); end
        checks++; if (first_wb !== 4) begin errors++; $display("FAIL rtype_wb_cycle got %0d want 4", first_wb); end
        checks++; if (o_regwe !== 1) begin errors++; $display("FAIL rtype_regwe got %0d want 1", o_regwe); end
        checks++; if (pc !== 10'd1) begin errors++; $display("FAIL rtype_pc got %0h want 1", pc); end
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL rtype_retired got %0d want 1", retired); end
        checks++; if (ir !== HW) begin errors++; $display("FAIL rtype_ir got %0h want %0h", ir, HW); end
        checks++; if (o_busy !== 6) begin errors++; $display("FAIL rtype_cycles got %0d want 6", o_busy); end
    endtask

    task automatic test_branch();
        for (int z = 1; z >= 0; z--) begin
            clear_prog();
            rom[0] = 9'h010; rom[1] = 9'h010; rom[2] = 9'h010; rom[3] = 9'h102;
            for (int i = 0; i < 64; i++) zq[i] = z[0];
            run_prog(0);
            checks++; if (o_timeout) begin errors++; $display("FAIL branch_timeout z=%0d got no done want done", z); end
            checks++;
            if (pc !== (z ? 10'd5 : 10'd4)) begin
                errors++;
                $display("FAIL branch_pc z=%0d got %0d want %0d", z, pc, z ? 5 : 4);
            end
            checks++; if (o_busy !== 17) begin errors++; $display("FAIL branch_cycles z=%0d got %0d want 17", z, o_busy); end
            checks++; if (retired !== 16'd4) begin errors++; $display("FAIL branch_retired z=%0d got %0d want 4", z, retired); end
        end
    endtask

    task automatic test_wrap();
        clear_prog();
        rom[0] = 9'h13F;
        zq[0] = 1'b1;
        run_prog(0);
        checks++; if (o_timeout) begin errors++; $display("FAIL wrap_timeout got no done want done"); end
        checks++; if (pc !== 10'h3FF) begin errors++; $display("FAIL wrap_pc got %0h want 3ff", pc); end
        checks++; if (o_busy !== 5) begin errors++; $display("FAIL wrap_cycles got %0d want 5", o_busy); end
    endtask

    task automatic test_load_store();
        clear_prog();
        rom[0] = 9'h0C0;
        wq[0] = 3;
        run_prog(0);
        checks++; if (o_timeout) begin errors++; $display("FAIL load_timeout got no done want done"); end
        checks++; if (o_memreq !== 4) begin errors++; $display("FAIL load_memreq got %0d want 4", o_memreq); end
        checks++; if (o_memwe !== 0) begin errors++; $display("FAIL load_memwe got %0d want 0", o_memwe); end
        checks++; if (first_wb !== 8) begin errors++; $display("FAIL load_wb_cycle got %0d want 8", first_wb); end
        checks++; if (o_busy !== 10) begin errors++; $display("FAIL load_cycles got %0d want 10", o_busy); end
        clear_prog();
        rom[0] = 9'h080;
        run_prog(0);
        checks++; if (o_timeout) begin errors++; $display("FAIL store_timeout got no done want done"); end
        checks++; if (o_memwe !== 1) begin errors++; $display("FAIL store_memwe got %0d want 1", o_memwe); end
        checks++; if (o_regwe !== 0) begin errors++; $display("FAIL store_regwe got %0d want 0", o_regwe); end
        checks++; if (o_busy !== 6) begin errors++; $display("FAIL store_cycles got %0d want 6", o_busy); end
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL store_retired got %0d want 1", retired); end
    endtask

    task automatic test_reset_in_mem();
        clear_prog();
        rom[0] = 9'h0C0;
        mem_ack = 1'b0;
        alu_zero = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmem_reach got mem_req=%0b want 1", mem_req); end
        reset = 1'b1;
        #1;
        checks++;
        if ({pc, ir, imem_rd, alu_en, mem_req, mem_we, reg_we, busy, done, retired} !== '0) begin
            errors++;
            $display("FAIL rstmem_outputs got pc=%0h ir=%0h mem_req=%0b busy=%0b want all zero",
                     pc, ir, mem_req, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, imem_rd, pc} !== '0) begin
            errors++;
            $display("FAIL rstmem_idle got busy=%0b imem_rd=%0b pc=%0h want 0 0 0", busy, imem_rd, pc);
        end
        rom[0] = 9'h010;
        run_prog(0);
        checks++; if (pc !== 10'd1 || o_busy !== 6) begin
            errors++;
            $display("FAIL rstmem_resume got pc=%0h cycles=%0d want pc=1 cycles=6", pc, o_busy);
        end
    endtask

    task automatic test_saturation();
        clear_prog();
        rom[0] = 9'h010; rom[1] = 9'h1AB; rom[2] = 9'h03C;
        run_prog(1);
        checks++; if (o_timeout) begin errors++; $display("FAIL sat_timeout got no done want done"); end
        checks++; if (retired !== 16'hFFFF) begin errors++; $display("FAIL sat_retired got %0h want ffff", retired); end
        checks++; if (pc !== 10'd3) begin errors++; $display("FAIL sat_pc got %0d want 3", pc); end
        checks++; if (o_busy !== 14) begin errors++; $display("FAIL sat_cycles got %0d want 14", o_busy); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int t = 0; t < 20; t++) begin
                clear_prog();
                for (int i = 0; i < 16; i++) begin
                    case ($urandom_range(3, 0))
                        0:       rom[i] = {2'b00, 7'($urandom)};
                        1:       rom[i] = {2'b01, 7'($urandom)};
                        2:       rom[i] = {2'b10, 7'($urandom)};
                        default: rom[i] = {2'b11, 7'($urandom)};
                    endcase
                end
                for (int i = 0; i < 64; i++) begin
                    zq[i] = 1'($urandom);
                    wq[i] = $urandom_range(3, 0);
                end
                model(16'd0);
                if (e_ok) break;
            end
            if (!e_ok) begin
                rom[0] = HW;
                model(16'd0);
            end
            run_prog(0);
            checks++; if (o_timeout) begin errors++; $display("FAIL rnd%0d_timeout got no done want done", r); end
            checks++; if (o_busy !== e_cyc) begin errors++; $display("FAIL rnd%0d_cycles got %0d want %0d", r, o_busy, e_cyc); end
            checks++; if (o_fetch !== e_fetch) begin errors++; $display("FAIL rnd%0d_fetch got %0d want %0d", r, o_fetch, e_fetch); end
            checks++; if (o_exec !== e_exec) begin errors++; $display("FAIL rnd%0d_exec got %0d want %0d", r, o_exec, e_exec); end
            checks++; if (o_regwe !== e_regwe) begin errors++; $display("FAIL rnd%0d_regwe got %0d want %0d", r, o_regwe, e_regwe); end
            checks++; if (o_memreq !== e_memreq) begin errors++; $display("FAIL rnd%0d_memreq got %0d want %0d", r, o_memreq, e_memreq); end
            checks++; if (o_memwe !== e_memwe) begin errors++; $display("FAIL rnd%0d_memwe got %0d want %0d", r, o_memwe, e_memwe); end
            checks++; if (int'(pc) !== e_pc) begin errors++; $display("FAIL rnd%0d_pc got %0h want %0h", r, pc, e_pc); end
            checks++; if (retired !== e_ret) begin errors++; $display("FAIL rnd%0d_retired got %0d want %0d", r, retired, e_ret); end
            checks++; if (done !== 1'b1 || ir !== HW) begin errors++; $display("FAIL rnd%0d_halt got done=%0b ir=%0h want 1 %0h", r, done, ir, HW); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_wrap();
        test_load_store();
        test_reset_in_mem();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
